// File: rtl/instr_fetch.sv
// Instruction fetch: IDLE/RUN/DONE sequencer, PC update with LUT-driven jumps and cmp flags.
// Optional macro FETCH_STALL_EN adds a Stall input that freezes PC, flags and state in RUN.
module instr_fetch #(
    parameter int PCW  = 10,
    parameter int LUTW = 5
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            Halt,
    input  logic            UncdJmp,
    input  logic            JType,
    input  logic [1:0]      JSel,
    input  logic [LUTW-1:0] TargetIdx,
    input  logic            CmpValid,
    input  logic            CmpEq,
    input  logic            CmpLt,
    input  logic            LutWrEn,
    input  logic [LUTW-1:0] LutAddr,
    input  logic [PCW-1:0]  LutData,
`ifdef FETCH_STALL_EN
    input  logic            Stall,
`endif
    output logic [PCW-1:0]  PC,
    output logic            Running,
    output logic            Done,
    output logic            Taken
);

    localparam int DEPTH = 1 << LUTW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e         state_q;
    logic [PCW-1:0] pc_q;
    logic           feq_q, flt_q;
    logic           running_q, done_q;
    logic [PCW-1:0] lut_q [DEPTH];

    logic           stall_w;
    logic           cond_w;
    logic           taken_w;
    logic [PCW-1:0] pc_inc_w;

`ifdef FETCH_STALL_EN
    assign stall_w = Stall;
`else
    assign stall_w = 1'b0;
`endif

    always_comb begin
        cond_w = 1'b0;
        case (JSel)
            2'b00: cond_w = feq_q;
            2'b01: cond_w = ~feq_q;
            2'b10: cond_w = flt_q;
            2'b11: cond_w = ~flt_q;
            default: cond_w = 1'b0;
        endcase
    end

    // Flags and LUT are read from their registers, so a same-cycle cmp or LUT write is not visible yet.
    assign taken_w  = (state_q == S_RUN) & ~stall_w & (UncdJmp | (JType & cond_w));
    assign pc_inc_w = pc_q + {{(PCW-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            feq_q     <= 1'b0;
            flt_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q   <= S_RUN;
                        pc_q      <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!stall_w) begin
                        if (CmpValid) begin
                            feq_q <= CmpEq;
                            flt_q <= CmpLt;
                        end
                        // Halt beats any jump: PC stays on the halting instruction.
                        if (Halt) begin
                            state_q   <= S_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            pc_q <= taken_w ? lut_q[TargetIdx] : pc_inc_w;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
        end else if (LutWrEn) begin
            lut_q[LutAddr] <= LutData;
        end
    end

    assign PC      = pc_q;
    assign Running = running_q;
    assign Done    = done_q;
    assign Taken   = taken_w;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PCW, default 10, the program-counter width in bits.
REQ-002 The block SHALL have parameter LUTW, default 5, the jump-target LUT index width (2**LUTW entries).
REQ-003 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Reset_n  input  1  the asynchronous, active-low reset.
REQ-005 Start  input  1  begins program execution from PC 0.
REQ-006 Halt  input  1  signals that the current instruction ends the program.
REQ-007 UncdJmp  input  1  unconditional jump, driven by the control decoder.
REQ-008 JType  input  1  jump-class instruction, driven by the control decoder.
REQ-009 JSel  input  2  condition select: 00 eq, 01 ne, 10 lt, 11 ge.
REQ-010 TargetIdx  input  LUTW  jump-target LUT index taken from the instruction immediate.
REQ-011 CmpValid  input  1  a cmp instruction executes this cycle.
REQ-012 CmpEq  input  1  ALU equal result for cmp.
REQ-013 CmpLt  input  1  ALU less-than result for cmp.
REQ-014 LutWrEn  input  1  LUT write enable.
REQ-015 LutAddr  input  LUTW  LUT write index.
REQ-016 LutData  input  PCW  LUT write value.
REQ-017 PC  output  PCW  registered address of the current instruction.
REQ-018 Running  output  1  high while the block is in the RUN state.
REQ-019 Done  output  1  high while the block is in the DONE state.
REQ-020 Taken  output  1  combinational; high when a jump resolves taken this cycle.

Function
REQ-021 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions: IDLE -> RUN on Start; RUN -> DONE on Halt; DONE -> RUN on Start; Start in RUN is ignored.
REQ-022 Entering RUN SHALL load PC = 0 on the same edge.
REQ-023 In RUN, Taken SHALL be UncdJmp | (JType & cond), where cond is eq: FlagEq, ne: !FlagEq, lt: FlagLt, ge: !FlagLt.
REQ-024 In RUN, the next PC SHALL be LUT[TargetIdx] if Taken, else PC+1 modulo 2**PCW, so that PC wraps from all-ones to 0.
REQ-025 Jump resolution SHALL have single-cycle latency with no bubble: the target appears on PC on the next edge.
REQ-026 In RUN, FlagEq and FlagLt SHALL register CmpEq and CmpLt when CmpValid is high, and hold their values otherwise.
REQ-027 A jump in the same cycle as CmpValid SHALL use the pre-update flags.
REQ-028 Halt in RUN SHALL win over any jump: PC holds and the state goes to DONE.
REQ-029 In IDLE and DONE, PC and flags SHALL hold, and Taken SHALL be 0.
REQ-030 A LUT write SHALL occur on the edge in any state.
REQ-031 A jump reading the index being written in the same cycle SHALL get the old entry.
REQ-032 UncdJmp asserted without JType SHALL still be taken.

Reset
REQ-033 While Reset_n is low, the block SHALL immediately force state IDLE, PC = 0, FlagEq = 0, FlagLt = 0 and all LUT entries = 0, giving Running = 0, Done = 0 and Taken = 0.
REQ-034 Reset asserted mid-RUN SHALL abort the program; no Start SHALL be remembered across reset.

Configuration
REQ-035 The block SHALL support the macro FETCH_STALL_EN.
REQ-036 With FETCH_STALL_EN defined, a 1-bit input Stall SHALL exist; when Stall is high in RUN, PC, flags and state SHALL hold, Taken SHALL be forced to 0, and Halt and CmpValid SHALL be ignored.
REQ-037 With FETCH_STALL_EN defined, LUT writes SHALL proceed regardless of Stall.
REQ-038 With FETCH_STALL_EN undefined, the Stall port SHALL be absent and behaviour SHALL be identical to Stall = 0.

Verification
REQ-039 Reset, then Start pulse, then 5 idle cycles -> PC sequence 0,1,2,3,4,5 with Running = 1.
REQ-040 Write LUT[3] = 0x155, then in RUN drive UncdJmp = 1 with TargetIdx = 3 -> Taken = 1 and PC = 0x155 on the next edge.
REQ-041 CmpValid with CmpEq = 1, then next cycle JType = 1 with JSel = 00 -> taken; JType with JSel = 01 -> not taken, PC+1.
REQ-042 CmpValid and a jump with JSel = 10 in the same cycle, with old FlagLt = 0 and CmpLt = 1 -> not taken; a lt jump on the following cycle -> taken.
REQ-043 PC = 0x3FF in RUN with no jump -> PC = 0x000; Halt together with UncdJmp -> DONE with PC held; Start then -> RUN with PC = 0.
REQ-044 Reset_n pulsed low mid-RUN at PC = 0x020 -> PC = 0, IDLE state and LUT cleared immediately, without waiting for a clock edge.
